// File: rtl/if_id_hazard_unit_pkg.sv
// Shared encodings for the IF/ID register and hazard unit: control-field
// values decoded upstream, stall-FSM states and the register-match helper.
package if_id_hazard_unit_pkg;

  localparam logic [1:0] REGSRC_ALU     = 2'd0;
  localparam logic [1:0] REGSRC_MEM     = 2'd1;
  localparam logic [1:0] REGSRC_PCPLUS4 = 2'd2;

  localparam logic [1:0] BRANCH_NONE = 2'd0;
  localparam logic [1:0] BRANCH_BEQ  = 2'd1;
  localparam logic [1:0] BRANCH_BNE  = 2'd2;

  localparam logic [1:0] JUMP_NONE = 2'd0;
  localparam logic [1:0] JUMP_J    = 2'd1;
  localparam logic [1:0] JUMP_REG  = 2'd2;
  localparam logic [1:0] JUMP_JAL  = 2'd3;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

  // Extra stall cycles spent in HZ_STALL after the detecting RUN cycle.
  localparam int         CNT_W      = 2;
  localparam logic [1:0] LONG_EXTRA = 2'd1;

  // A producer matches a source operand only if it really writes a
  // non-zero register that a live ID instruction actually reads.
  function automatic logic reg_match(
    input logic       wr_en,
    input logic [4:0] wr_reg,
    input logic [4:0] src_reg,
    input logic       src_used,
    input logic       id_valid
  );
    return wr_en && (wr_reg != 5'd0) && (wr_reg == src_reg) && src_used && id_valid;
  endfunction

endpackage

// File: rtl/if_id_hazard_unit_hazard_detect.sv
// Combinational classification of unforwardable hazards into the number of
// stall cycles the ID instruction must wait (0, 1 or 2).
module hazard_detect
  import if_id_hazard_unit_pkg::*;
(
  input  logic       ID_valid,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic [1:0] ID_Branch,
  input  logic [1:0] ID_Jump,
  input  logic       EX_RegWrite,
  input  logic [1:0] EX_RegSrc,
  input  logic [4:0] EX_WriteReg,
  input  logic       MEM_RegWrite,
  input  logic [1:0] MEM_RegSrc,
  input  logic [4:0] MEM_WriteReg,
  output logic [1:0] need
);

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic ex_m, mem_m;
  logic use_reg_at_id;
  logic ex_load, ex_alu, mem_load;

  assign ex_rs  = reg_match(EX_RegWrite,  EX_WriteReg,  ID_rs, ID_UseRs, ID_valid);
  assign ex_rt  = reg_match(EX_RegWrite,  EX_WriteReg,  ID_rt, ID_UseRt, ID_valid);
  assign mem_rs = reg_match(MEM_RegWrite, MEM_WriteReg, ID_rs, ID_UseRs, ID_valid);
  assign mem_rt = reg_match(MEM_RegWrite, MEM_WriteReg, ID_rt, ID_UseRt, ID_valid);

  assign ex_m  = ex_rs | ex_rt;
  assign mem_m = mem_rs | mem_rt;

  // Branches and jr compare/consume operands in ID, one stage earlier than ALU ops.
  assign use_reg_at_id = (ID_Branch != BRANCH_NONE) || (ID_Jump == JUMP_REG);

  assign ex_load  = ex_m  && (EX_RegSrc  == REGSRC_MEM);
  assign ex_alu   = ex_m  && (EX_RegSrc  == REGSRC_ALU);
  assign mem_load = mem_m && (MEM_RegSrc == REGSRC_MEM);

  always_comb begin
    need = NEED_NONE;
    if (use_reg_at_id && ex_load) begin
      need = NEED_TWO;
    end else if (ex_load) begin
      need = NEED_ONE;
    end else if (use_reg_at_id && ex_alu) begin
      need = NEED_ONE;
    end else if (use_reg_at_id && mem_load) begin
      need = NEED_ONE;
    end
  end

endmodule

// File: rtl/if_id_hazard_unit.sv
// IF/ID pipeline register with load-use / branch-operand stall control and a
// saturating stall-cycle counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   HZ_RUN   | normal flow; stall this cycle iff the detector reports need
//   HZ_STALL | forced stall of a two-cycle hazard; detection ignored; cnt
//            | counts down and returns to HZ_RUN at terminal count
module if_id_hazard_unit
  import if_id_hazard_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       IF_PC,
  input  logic [31:0]       IF_Instr,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic [1:0]        ID_Branch,
  input  logic [1:0]        ID_Jump,
  input  logic              ID_Redirect,
  input  logic              EX_RegWrite,
  input  logic [1:0]        EX_RegSrc,
  input  logic [4:0]        EX_WriteReg,
  input  logic              MEM_RegWrite,
  input  logic [1:0]        MEM_RegSrc,
  input  logic [4:0]        MEM_WriteReg,
  output logic [31:0]       ID_PC,
  output logic [31:0]       ID_Instr,
  output logic              ID_valid,
  output logic [4:0]        ID_rs,
  output logic [4:0]        ID_rt,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IDEXFlush,
  output logic [PERF_W-1:0] stall_cycles
);

  hz_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_dec;
  logic [1:0]       need;
  logic             stall;

  assign ID_rs = ID_Instr[25:21];
  assign ID_rt = ID_Instr[20:16];

  hazard_detect u_hazard_detect (
    .ID_valid     (ID_valid),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_UseRs     (ID_UseRs),
    .ID_UseRt     (ID_UseRt),
    .ID_Branch    (ID_Branch),
    .ID_Jump      (ID_Jump),
    .EX_RegWrite  (EX_RegWrite),
    .EX_RegSrc    (EX_RegSrc),
    .EX_WriteReg  (EX_WriteReg),
    .MEM_RegWrite (MEM_RegWrite),
    .MEM_RegSrc   (MEM_RegSrc),
    .MEM_WriteReg (MEM_WriteReg),
    .need         (need)
  );

  assign cnt_dec = cnt - CNT_W'(1);
  assign stall   = (state == HZ_STALL) || (need != NEED_NONE);

  assign PCWrite   = ~stall;
  assign IFIDWrite = ~stall;
  assign IDEXFlush = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HZ_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (need == NEED_TWO) begin
            state <= HZ_STALL;
            cnt   <= LONG_EXTRA;
          end
        end
        HZ_STALL: begin
          cnt <= cnt_dec;
          if (cnt_dec == '0) begin
            state <= HZ_RUN;
          end
        end
      endcase
    end
  end

  // A redirect during a stall is dropped; the branch re-resolves afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_PC    <= 32'h0;
      ID_Instr <= NOP_INSTR;
      ID_valid <= 1'b0;
    end else if (!stall) begin
      ID_PC <= IF_PC;
      if (ID_Redirect) begin
        ID_Instr <= NOP_INSTR;
        ID_valid <= 1'b0;
      end else begin
        ID_Instr <= IF_Instr;
        ID_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
